radix4_frame_buffer: RTL and testbench
======================================

RADIX4_FRAME_BUFFER -- requirements
Module: radix4_frame_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each real and imaginary sample.
REQ-002 SHALL have parameter LANES, default 4: samples per input beat; legal values 2 and 4.
REQ-003 SHALL have parameter SEG, default 4: input beats per frame; power of 2, at least 1. Frame size is N = LANES*SEG samples.
REQ-004 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush of all frame state.
REQ-007 SHALL have port in_valid, input, 1 bit: input beat present.
REQ-008 SHALL have port in_ready, output, 1 bit: input beat can be accepted.
REQ-009 SHALL have port in_real, input, LANES*WIDTH bits: lane i is bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port in_imag, input, LANES*WIDTH bits, with the same lane packing as in_real.
REQ-011 SHALL have port out_valid, output, 1 bit: serial sample present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the sample.
REQ-013 SHALL have port out_real, output, WIDTH bits: serial real sample.
REQ-014 SHALL have port out_imag, output, WIDTH bits: serial imaginary sample.
REQ-015 SHALL have port out_first, output, 1 bit: marks frame sample 0.
REQ-016 SHALL have port out_last, output, 1 bit: marks frame sample N-1.
REQ-017 SHALL have port frames_pending, output, 2 bits: count of banks in the FULL state (0..2).

Function
REQ-018 SHALL contain two banks, B0 and B1, each holding SEG x LANES complex entries, plus a write-bank pointer wb, a read-bank pointer rb, a write counter wcnt (0..SEG-1) and a read counter rcnt (0..N-1).
REQ-019 Each bank SHALL have state EMPTY, FILLING or FULL:
- EMPTY->FILLING on the first beat accepted into that bank.
- FILLING->FULL on the beat accepted with wcnt==SEG-1.
- FULL->EMPTY on the sample handshaken with rcnt==N-1.
REQ-020 in_ready SHALL equal (state[wb] != FULL), decoded from registered state only.
REQ-021 On in_valid && in_ready, all lanes SHALL be stored at bank[wb] beat wcnt, and wcnt SHALL increment. At wcnt==SEG-1, wcnt SHALL wrap to 0 and wb SHALL toggle.
REQ-022 out_valid SHALL equal (state[rb]==FULL).
REQ-023 While out_valid is high, out_real/out_imag SHALL present bank[rb] entry beat (rcnt mod SEG), lane (rcnt / SEG). Output order is lane-major and oldest beat first: lane 0 beats 0..SEG-1, then lane 1, and so on.
REQ-024 On out_valid && out_ready, rcnt SHALL increment. At rcnt==N-1, rcnt SHALL wrap to 0 and rb SHALL toggle.
REQ-025 out_first SHALL equal out_valid && rcnt==0, and out_last SHALL equal out_valid && rcnt==N-1.
REQ-026 out_real and out_imag SHALL be 0 whenever out_valid is low.
REQ-027 Latency: out_valid SHALL rise on the clock edge after the final beat of a frame is accepted.
REQ-028 A bank freed by the final read SHALL raise in_ready one cycle later; a write and the final read of the same bank in one cycle is impossible by construction.
REQ-029 Writing one bank while the other drains SHALL proceed concurrently with no stall. With out_ready held high, sustained input throughput SHALL be 1 beat per LANES cycles.
REQ-030 out_valid SHALL stay high and out_real/out_imag SHALL stay stable while out_ready is low.
REQ-031 clear SHALL set both banks EMPTY and wb, rb, wcnt and rcnt to 0 on the next edge. clear SHALL take priority over simultaneous handshakes; bank data need not be cleared.
REQ-032 frames_pending SHALL equal the number of banks in FULL, registered.

Reset
REQ-033 reset SHALL asynchronously force: both banks EMPTY; wb=rb=0; wcnt=rcnt=0; all bank entries 0; in_ready=1; out_valid=0; out_first=0; out_last=0; out_real=0; out_imag=0; frames_pending=0.
REQ-034 Assertion of reset mid-frame SHALL discard all partial and complete frames; no stale sample SHALL appear after release.

Verification (WIDTH=16, LANES=4, SEG=4 unless stated)
REQ-035 Reset held, then released: in_ready=1, out_valid=0, outputs 0, frames_pending=0.
REQ-036 Four beats, lane i real=10*k+i for beat k, imag=-real, out_ready=1: out_valid rises 1 cycle after beat 3. Reals stream 0,10,20,30,1,11,21,31,2,...,33; out_first on 0, out_last on 33.
REQ-037 out_ready=0 with 9 beats offered back-to-back: in_ready falls after beat 8, frames_pending=2, beat 9 held. Raise out_ready: 16 samples drain, then in_ready=1 the next cycle and beat 9 is accepted.
REQ-038 Random out_ready and in_valid over 50 frames: output sequence equals the golden lane-major reorder, with no loss or duplication.
REQ-039 clear asserted after 2 beats with one full frame pending: next cycle out_valid=0, frames_pending=0, and a fresh frame reorders correctly.
REQ-040 LANES=2, SEG=8, WIDTH=24: 8 beats produce 16 samples, lane 0 beats 0..7 then lane 1; out_last on sample 15.

Source files
------------

// File: rtl/radix4_frame_buffer.sv
// Double-banked frame buffer: accepts LANES-wide beats and emits each complete
// frame as a lane-major serial stream while the other bank keeps filling.
module radix4_frame_buffer #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int SEG   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_real,
  input  logic [LANES*WIDTH-1:0] in_imag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_real,
  output logic [WIDTH-1:0]       out_imag,
  output logic                   out_first,
  output logic                   out_last,
  output logic [1:0]             frames_pending
);

  localparam int N   = LANES * SEG;
  localparam int WCW = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int RCW = $clog2(N);
  localparam int LW  = $clog2(LANES);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  bank_state_t r_state [2];
  bank_state_t w_state_nxt [2];

  logic             r_wb;
  logic             r_rb;
  logic [WCW-1:0]   r_wcnt;
  logic [RCW-1:0]   r_rcnt;
  logic [1:0]       r_frames_pending;
  logic [WIDTH-1:0] r_mem_re [2][SEG][LANES];
  logic [WIDTH-1:0] r_mem_im [2][SEG][LANES];

  logic             w_wr_fire;
  logic             w_rd_fire;
  logic             w_wr_last;
  logic             w_rd_last;
  logic [WCW-1:0]   w_rd_beat;
  logic [LW-1:0]    w_rd_lane;
  logic [1:0]       w_pend_nxt;

  assign w_wr_fire = in_valid && in_ready;
  assign w_rd_fire = out_valid && out_ready;
  assign w_wr_last = (r_wcnt == WCW'(SEG - 1));
  assign w_rd_last = (r_rcnt == RCW'(N - 1));
  // Lane-major read order: the low part of rcnt walks beats, the high part lanes.
  assign w_rd_beat = WCW'(r_rcnt % RCW'(SEG));
  assign w_rd_lane = LW'(r_rcnt / RCW'(SEG));

  // Bank state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
    end
  end

  // Bank next-state logic; a bank cannot be written and finally read in one
  // cycle because writes need a non-FULL bank and reads need a FULL one.
  always_comb begin
    w_state_nxt[0] = r_state[0];
    w_state_nxt[1] = r_state[1];
    if (clear) begin
      w_state_nxt[0] = EMPTY;
      w_state_nxt[1] = EMPTY;
    end else begin
      if (w_wr_fire) begin
        w_state_nxt[r_wb] = w_wr_last ? FULL : FILLING;
      end else begin
        w_state_nxt[r_wb] = w_state_nxt[r_wb];
      end
      if (w_rd_fire && w_rd_last) begin
        w_state_nxt[r_rb] = EMPTY;
      end else begin
        w_state_nxt[r_rb] = w_state_nxt[r_rb];
      end
    end
  end

  // Output decode from registered state and storage
  always_comb begin
    in_ready  = (r_state[r_wb] != FULL);
    out_valid = (r_state[r_rb] == FULL);
    out_first = out_valid && (r_rcnt == RCW'(0));
    out_last  = out_valid && w_rd_last;
    if (out_valid) begin
      out_real = r_mem_re[r_rb][w_rd_beat][w_rd_lane];
      out_imag = r_mem_im[r_rb][w_rd_beat][w_rd_lane];
    end else begin
      out_real = '0;
      out_imag = '0;
    end
    frames_pending = r_frames_pending;
  end

  assign w_pend_nxt = 2'(w_state_nxt[0] == FULL) + 2'(w_state_nxt[1] == FULL);

  // Write/read pointers, counters and pending-frame count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wb             <= 1'b0;
      r_rb             <= 1'b0;
      r_wcnt           <= '0;
      r_rcnt           <= '0;
      r_frames_pending <= 2'd0;
    end else if (clear) begin
      r_wb             <= 1'b0;
      r_rb             <= 1'b0;
      r_wcnt           <= '0;
      r_rcnt           <= '0;
      r_frames_pending <= 2'd0;
    end else begin
      r_frames_pending <= w_pend_nxt;
      if (w_wr_fire) begin
        r_wcnt <= w_wr_last ? WCW'(0) : r_wcnt + WCW'(1);
        r_wb   <= w_wr_last ? ~r_wb : r_wb;
      end
      if (w_rd_fire) begin
        r_rcnt <= w_rd_last ? RCW'(0) : r_rcnt + RCW'(1);
        r_rb   <= w_rd_last ? ~r_rb : r_rb;
      end
    end
  end

  // Sample storage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < SEG; s++) begin
          for (int l = 0; l < LANES; l++) begin
            r_mem_re[b][s][l] <= '0;
            r_mem_im[b][s][l] <= '0;
          end
        end
      end
    end else if (w_wr_fire && !clear) begin
      for (int l = 0; l < LANES; l++) begin
        r_mem_re[r_wb][r_wcnt][l] <= in_real[l*WIDTH +: WIDTH];
        r_mem_im[r_wb][r_wcnt][l] <= in_imag[l*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_radix4_frame_buffer.sv
// Self-checking bench: a frame-level scoreboard predicts the lane-major output
// stream, readiness and pending-frame count for the buffer.
module tb_radix4_frame_buffer;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_real;
  logic [63:0] in_imag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_real;
  logic [15:0] out_imag;
  logic        out_first;
  logic        out_last;
  logic [1:0]  frames_pending;

  logic        d2_clear;
  logic        d2_in_valid;
  logic        d2_in_ready;
  logic [47:0] d2_in_real;
  logic [47:0] d2_in_imag;
  logic        d2_out_valid;
  logic        d2_out_ready;
  logic [23:0] d2_out_real;
  logic [23:0] d2_out_imag;
  logic        d2_out_first;
  logic        d2_out_last;
  logic [1:0]  d2_frames_pending;

  radix4_frame_buffer #(.WIDTH(16), .LANES(4), .SEG(4)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_first(out_first), .out_last(out_last), .frames_pending(frames_pending)
  );

  radix4_frame_buffer #(.WIDTH(24), .LANES(2), .SEG(8)) dut2 (
    .clock(clock), .reset(reset), .clear(d2_clear),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_real(d2_in_real), .in_imag(d2_in_imag),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_real(d2_out_real), .out_imag(d2_out_imag),
    .out_first(d2_out_first), .out_last(d2_out_last), .frames_pending(d2_frames_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: complete frames queued as serial samples, plus the partial frame
  logic [15:0] exp_re[$];
  logic [15:0] exp_im[$];
  logic [15:0] cur_re[4][4];
  logic [15:0] cur_im[4][4];
  int          wbeat = 0;
  int          popped = 0;
  int          pop_total = 0;
  logic [15:0] obs_q[$];

  task automatic model_reset();
    exp_re.delete();
    exp_im.delete();
    wbeat  = 0;
    popped = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance model, clock.
  task automatic step(input logic iv, input logic [63:0] re, input logic [63:0] im,
                      input logic ordy, input logic clr, output logic acc);
    int  pend;
    logic rd;
    in_valid  = iv;
    in_real   = re;
    in_imag   = im;
    out_ready = ordy;
    clear     = clr;
    #1;
    pend = (exp_re.size() + 15) / 16;
    checks++;
    if (in_ready !== (pend < 2)) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b", in_ready, (pend < 2));
    end
    checks++;
    if (out_valid !== (exp_re.size() > 0)) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", out_valid, (exp_re.size() > 0));
    end
    checks++;
    if (frames_pending !== 2'(pend)) begin
      errors++;
      $display("FAIL frames_pending: got %0d expected %0d", frames_pending, pend);
    end
    if (exp_re.size() > 0) begin
      checks++;
      if (out_real !== exp_re[0] || out_imag !== exp_im[0]) begin
        errors++;
        $display("FAIL sample %0d: got %h/%h expected %h/%h", popped, out_real, out_imag,
                 exp_re[0], exp_im[0]);
      end
      checks++;
      if (out_first !== (popped % 16 == 0) || out_last !== (popped % 16 == 15)) begin
        errors++;
        $display("FAIL first_last idx %0d: got %b%b expected %b%b", popped % 16, out_first,
                 out_last, (popped % 16 == 0), (popped % 16 == 15));
      end
    end else begin
      checks++;
      if (out_real !== 16'd0 || out_imag !== 16'd0 || out_first !== 1'b0 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs: got %h/%h %b%b expected 0", out_real, out_imag,
                 out_first, out_last);
      end
    end
    acc = iv && (pend < 2) && !clr;
    rd  = (exp_re.size() > 0) && ordy && !clr;
    if (clr) begin
      model_reset();
    end else begin
      if (rd) begin
        obs_q.push_back(out_real);
        void'(exp_re.pop_front());
        void'(exp_im.pop_front());
        popped++;
        pop_total++;
      end
      if (acc) begin
        for (int l = 0; l < 4; l++) begin
          cur_re[wbeat][l] = re[l*16 +: 16];
          cur_im[wbeat][l] = im[l*16 +: 16];
        end
        wbeat++;
        if (wbeat == 4) begin
          for (int l = 0; l < 4; l++) begin
            for (int b = 0; b < 4; b++) begin
              exp_re.push_back(cur_re[b][l]);
              exp_im.push_back(cur_im[b][l]);
            end
          end
          wbeat = 0;
        end
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic feed_random_beats(input int n, input logic ordy);
    logic acc;
    int   got = 0;
    int   cyc = 0;
    while (got < n && cyc < 200) begin
      step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, ordy, 1'b0, acc);
      if (acc) got++;
      cyc++;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL feed_timeout: got %0d beats expected %0d", got, n);
    end
  endtask

  task automatic drain();
    logic acc;
    int   cyc = 0;
    while (exp_re.size() > 0 && cyc < 300) begin
      step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, acc);
      cyc++;
    end
    step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, acc);
    checks++;
    if (exp_re.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_re.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || frames_pending !== 2'd0 ||
        out_real !== 16'd0 || out_imag !== 16'd0 || out_first !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got rdy=%b vld=%b pend=%0d re=%h im=%h expected 1 0 0 0 0",
               in_ready, out_valid, frames_pending, out_real, out_imag);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || frames_pending !== 2'd0 || out_real !== 16'd0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b vld=%b pend=%0d expected 1 0 0",
               in_ready, out_valid, frames_pending);
    end
    checks++;
    if (d2_in_ready !== 1'b1 || d2_out_valid !== 1'b0 || d2_frames_pending !== 2'd0) begin
      errors++;
      $display("FAIL reset_dut2: got rdy=%b vld=%b pend=%0d expected 1 0 0",
               d2_in_ready, d2_out_valid, d2_frames_pending);
    end
    model_reset();
  endtask

  task automatic test_single_frame();
    logic        acc;
    logic [63:0] re;
    logic [63:0] im;
    int          cyc = 0;
    obs_q.delete();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        re[i*16 +: 16] = 16'(10 * k + i);
        im[i*16 +: 16] = 16'(-(10 * k + i));
      end
      step(1'b1, re, im, 1'b1, 1'b0, acc);
    end
    checks++;
    if (out_valid !== 1'b1 || out_first !== 1'b1 || out_real !== 16'd0) begin
      errors++;
      $display("FAIL frame_latency: got vld=%b first=%b re=%h expected 1 1 0",
               out_valid, out_first, out_real);
    end
    while (obs_q.size() < 16 && cyc < 40) begin
      step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, acc);
      cyc++;
    end
    checks++;
    if (obs_q.size() != 16) begin
      errors++;
      $display("FAIL frame_count: got %0d expected 16", obs_q.size());
    end else begin
      for (int s = 0; s < 16; s++) begin
        checks++;
        if (obs_q[s] !== 16'(10 * (s % 4) + s / 4)) begin
          errors++;
          $display("FAIL frame_order[%0d]: got %0d expected %0d", s, obs_q[s], 10 * (s % 4) + s / 4);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        acc;
    logic [63:0] b9;
    int          n = 0;
    feed_random_beats(8, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || frames_pending !== 2'd2) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b pend=%0d expected 0 2", in_ready, frames_pending);
    end
    b9 = {$urandom, $urandom};
    for (int c = 0; c < 3; c++) begin
      step(1'b1, b9, ~b9, 1'b0, 1'b0, acc);
    end
    acc = 1'b0;
    while (!acc && n < 40) begin
      step(1'b1, b9, ~b9, 1'b1, 1'b0, acc);
      n++;
    end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL bp_release: got beat 9 accepted on cycle %0d expected 17", n);
    end
    feed_random_beats(3, 1'b1);
    drain();
  endtask

  task automatic test_clear();
    logic acc;
    feed_random_beats(6, 1'b0);
    step(1'b1, {$urandom, $urandom}, 64'd0, 1'b1, 1'b1, acc);
    checks++;
    if (out_valid !== 1'b0 || frames_pending !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear: got vld=%b pend=%0d rdy=%b expected 0 0 1",
               out_valid, frames_pending, in_ready);
    end
    feed_random_beats(4, 1'b1);
    drain();
  endtask

  task automatic test_random();
    logic acc;
    int   beats = 0;
    int   cyc = 0;
    int   base = pop_total;
    while (beats < 200 && cyc < 4000) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, 1'b0, acc);
      if (acc) beats++;
      cyc++;
    end
    checks++;
    if (beats != 200) begin
      errors++;
      $display("FAIL random_feed: got %0d beats expected 200", beats);
    end
    drain();
    checks++;
    if (pop_total - base != 800) begin
      errors++;
      $display("FAIL random_count: got %0d samples expected 800", pop_total - base);
    end
  endtask

  task automatic test_reset_midframe();
    logic acc;
    feed_random_beats(6, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || frames_pending !== 2'd0 || in_ready !== 1'b1 || out_real !== 16'd0) begin
      errors++;
      $display("FAIL reset_async: got vld=%b pend=%0d rdy=%b re=%h expected 0 0 1 0",
               out_valid, frames_pending, in_ready, out_real);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) step(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, acc);
    feed_random_beats(4, 1'b1);
    drain();
  endtask

  task automatic test_two_lane();
    logic [23:0] ref_re[8][2];
    logic [23:0] ref_im[8][2];
    int          k = 0;
    int          cyc = 0;
    int          ln;
    int          bt;
    d2_out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      for (int l = 0; l < 2; l++) begin
        ref_re[b][l] = 24'($urandom);
        ref_im[b][l] = 24'($urandom);
        d2_in_real[l*24 +: 24] = ref_re[b][l];
        d2_in_imag[l*24 +: 24] = ref_im[b][l];
      end
      d2_in_valid = 1'b1;
      #1;
      checks++;
      if (d2_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL d2_in_ready beat %0d: got %b expected 1", b, d2_in_ready);
      end
      @(negedge clock);
    end
    d2_in_valid = 1'b0;
    #1;
    checks++;
    if (d2_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL d2_latency: got %b expected 1", d2_out_valid);
    end
    while (k < 16 && cyc < 40) begin
      #1;
      if (d2_out_valid) begin
        ln = k / 8;
        bt = k % 8;
        checks++;
        if (d2_out_real !== ref_re[bt][ln] || d2_out_imag !== ref_im[bt][ln] ||
            d2_out_first !== (k == 0) || d2_out_last !== (k == 15)) begin
          errors++;
          $display("FAIL d2_sample %0d: got %h/%h %b%b expected %h/%h %b%b", k, d2_out_real,
                   d2_out_imag, d2_out_first, d2_out_last, ref_re[bt][ln], ref_im[bt][ln],
                   (k == 0), (k == 15));
        end
        k++;
      end
      @(negedge clock);
      cyc++;
    end
    #1;
    checks++;
    if (k != 16 || d2_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL d2_count: got %0d samples vld=%b expected 16 0", k, d2_out_valid);
    end
  endtask

  initial begin
    reset        = 1'b1;
    clear        = 1'b0;
    in_valid     = 1'b0;
    in_real      = 64'd0;
    in_imag      = 64'd0;
    out_ready    = 1'b0;
    d2_clear     = 1'b0;
    d2_in_valid  = 1'b0;
    d2_in_real   = 48'd0;
    d2_in_imag   = 48'd0;
    d2_out_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_clear();
    test_random();
    test_reset_midframe();
    test_two_lane();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
